// File: rtl/shift_unit_arbiter.sv
// shift_unit_arbiter: two requesters (A = integer ALU, B = load/store align)
// share one DATA_WIDTH-bit shifter (SLL, SRL, SRA, ROL). One operation in
// flight at a time: IDLE (grant + latch) -> EXEC (shift) -> RESP (hold result
// until res_ready).
// Optional build macro SHIFT_RR_EN: round-robin arbitration between A and B;
// when undefined, A has fixed priority over B and no pointer register exists.
module shift_unit_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req,
    input  logic [1:0]            a_op,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [NUM_WIDTH-1:0]  a_amt,
    output logic                  a_gnt,
    input  logic                  b_req,
    input  logic [1:0]            b_op,
    input  logic [DATA_WIDTH-1:0] b_data,
    input  logic [NUM_WIDTH-1:0]  b_amt,
    output logic                  b_gnt,
    output logic                  res_valid,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_id,
    input  logic                  res_ready,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_e;

    state_e                  state_q, state_d;
    op_e                     op_q, op_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [NUM_WIDTH-1:0]    amt_q, amt_d;
    logic                    id_q, id_d;
    logic                    res_valid_q, res_valid_d;
    logic [DATA_WIDTH-1:0]   res_data_q, res_data_d;
    logic                    res_id_q, res_id_d;
    logic                    pick_a;
    logic                    in_idle;
    logic [DATA_WIDTH-1:0]   shift_res;

`ifdef SHIFT_RR_EN
    // 0 = A preferred, 1 = B preferred.
    logic                    ptr_q, ptr_d;
`endif

    // Arbitration: decide which requester wins if the unit is idle.
    always_comb begin
`ifdef SHIFT_RR_EN
        // A lone requester always wins; the pointer only breaks ties.
        pick_a = a_req && (!b_req || !ptr_q);
`else
        pick_a = a_req;
`endif
    end

    // Grants are combinational so operands are latched in the grant cycle;
    // they are masked while reset is asserted.
    assign in_idle = rst_n && (state_q == ST_IDLE);
    assign a_gnt   = in_idle && pick_a;
    assign b_gnt   = in_idle && b_req && !pick_a;
    assign busy    = (state_q != ST_IDLE);

    // Shift datapath on the latched operands; amount is already modulo width.
    always_comb begin
        unique case (op_q)
            OP_SLL:  shift_res = data_q << amt_q;
            OP_SRL:  shift_res = data_q >> amt_q;
            OP_SRA:  shift_res = $unsigned($signed(data_q) >>> amt_q);
            OP_ROL:  shift_res = (data_q << amt_q) | (data_q >> (DATA_WIDTH - int'(amt_q)));
            default: shift_res = data_q;
        endcase
    end

    // Next-state logic for the FSM, operand latches and result register.
    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path through the case leaves a signal unassigned and no latch is inferred.
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        amt_d       = amt_q;
        id_d        = id_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
`ifdef SHIFT_RR_EN
        ptr_d       = ptr_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (a_gnt) begin
                    op_d    = op_e'(a_op);
                    data_d  = a_data;
                    amt_d   = a_amt;
                    id_d    = 1'b0;
                    state_d = ST_EXEC;
`ifdef SHIFT_RR_EN
                    ptr_d   = 1'b1;
`endif
                end else if (b_gnt) begin
                    op_d    = op_e'(b_op);
                    data_d  = b_data;
                    amt_d   = b_amt;
                    id_d    = 1'b1;
                    state_d = ST_EXEC;
`ifdef SHIFT_RR_EN
                    ptr_d   = 1'b0;
`endif
                end
            end
            ST_EXEC: begin
                res_data_d  = shift_res;
                res_valid_d = 1'b1;
                res_id_d    = id_q;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_SLL;
            data_q      <= '0;
            amt_q       <= '0;
            id_q        <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
`ifdef SHIFT_RR_EN
            ptr_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            amt_q       <= amt_d;
            id_q        <= id_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
`ifdef SHIFT_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Testbench for shift_unit_arbiter: directed cases plus random traffic,
// checked by a transaction-level model and a result scoreboard.
module tb_shift_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 1'b0, b_req = 1'b0;
    logic [1:0]  a_op = 2'b00, b_op = 2'b00;
    logic [31:0] a_data = '0, b_data = '0;
    logic [4:0]  a_amt = '0, b_amt = '0;
    logic        a_gnt, b_gnt;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_id;
    logic        res_ready = 1'b1;
    logic        busy;

    shift_unit_arbiter #(.DATA_WIDTH(32), .NUM_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_op(a_op), .a_data(a_data), .a_amt(a_amt), .a_gnt(a_gnt),
        .b_req(b_req), .b_op(b_op), .b_data(b_data), .b_amt(b_amt), .b_gnt(b_gnt),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
        .res_ready(res_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        id;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_hs    = 0;
    int   n_agnt  = 0;
    bit   model_on = 1'b0;
    int   m_phase = 0;     // 0 idle, 1 computing, 2 result pending
    bit   m_pref  = 1'b0;  // preferred requester when both ask (0 = A)

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference shift: applies a one-bit step 'amt' times.
    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d, input int amt);
        logic [31:0] r = d;
        for (int i = 0; i < amt; i++) begin
            case (op)
                2'b00: r = {r[30:0], 1'b0};
                2'b01: r = {1'b0, r[31:1]};
                2'b10: r = {r[31], r[31:1]};
                default: r = {r[30:0], r[31]};
            endcase
        end
        return r;
    endfunction

    // Transaction model: predicts grants/busy/valid and pushes expected results.
    always @(negedge clk) begin
        if (model_on) begin
            bit exp_a, exp_b;
            exp_a = rst_n && (m_phase == 0) && a_req && (!b_req || !m_pref);
            exp_b = rst_n && (m_phase == 0) && b_req && !exp_a;
            check("a_gnt", a_gnt, exp_a);
            check("b_gnt", b_gnt, exp_b);
            check("busy", busy, m_phase != 0);
            check("res_valid", res_valid, m_phase == 2);
            if (a_gnt) n_agnt++;
            if (!rst_n) begin
                m_phase = 0;
                m_pref  = 1'b0;
                sb.delete();
            end else begin
                case (m_phase)
                    0: if (exp_a || exp_b) begin
                        if (exp_a) sb.push_back('{ref_shift(a_op, a_data, int'(a_amt)), 1'b0});
                        else       sb.push_back('{ref_shift(b_op, b_data, int'(b_amt)), 1'b1});
                        m_phase = 1;
`ifdef SHIFT_RR_EN
                        m_pref = exp_a;
`endif
                    end
                    1: m_phase = 2;
                    default: if (res_ready) m_phase = 0;
                endcase
            end
        end
    end

    // Result monitor: compares each presented result with the scoreboard head.
    always @(negedge clk) begin
        if (model_on && rst_n && res_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got %h with no expected entry", res_data);
            end else begin
                check("res_data", res_data, sb[0].data);
                check("res_id", res_id, sb[0].id);
                if (res_ready) begin
                    n_hs++;
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Raise a request, wait (bounded) for its grant, drop it after latching.
    task automatic issue(input bit which, input logic [1:0] op, input logic [31:0] d, input logic [4:0] amt);
        bit got = 1'b0;
        @(posedge clk); #1;
        if (!which) begin a_req = 1'b1; a_op = op; a_data = d; a_amt = amt; end
        else        begin b_req = 1'b1; b_op = op; b_data = d; b_amt = amt; end
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = which ? b_gnt : a_gnt;
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL grant_timeout: requester %0d got no grant within 60 cycles", which);
        end
        @(posedge clk); #1;
        if (!which) a_req = 1'b0; else b_req = 1'b0;
    endtask

    // Issue with res_ready high and check latency and value against a constant.
    task automatic issue_expect(input bit which, input logic [1:0] op, input logic [31:0] d,
                                input logic [4:0] amt, input logic [31:0] exp, input string name);
        res_ready = 1'b1;
        issue(which, op, d, amt);
        @(negedge clk); check({name, "_early_valid"}, res_valid, 0);
        @(negedge clk); check({name, "_valid"}, res_valid, 1);
        check(name, res_data, exp);
        check({name, "_id"}, res_id, which);
        @(negedge clk); check({name, "_busy_after"}, busy, 0);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            done = !busy && !res_valid;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: busy=%0b res_valid=%0b", busy, res_valid);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    initial begin
        int   hs0, agnt0;
        logic grants[$];
        logic exp_seq[4];

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_on = 1'b1;
        @(negedge clk);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_id", res_id, 0);
        check("rst_busy", busy, 0);

        // A only, SLL by 4.
        issue_expect(1'b0, 2'b00, 32'h0000_00F1, 5'd4, 32'h0000_0F10, "a_sll4");

        // Op coverage on B.
        issue_expect(1'b1, 2'b01, 32'h8000_0000, 5'd8, 32'h0080_0000, "b_srl8");
        issue_expect(1'b1, 2'b10, 32'h8000_0000, 5'd8, 32'hFF80_0000, "b_sra8");
        issue_expect(1'b1, 2'b11, 32'h1234_5678, 5'd8, 32'h3456_7812, "b_rol8");
        issue_expect(1'b1, 2'b00, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, "b_sll0");
        issue_expect(1'b0, 2'b11, 32'h8000_0001, 5'd31, 32'hC000_0000, "a_rol31");

        // Backpressure with B requesting again while the result is held.
        res_ready = 1'b0;
        issue(1'b1, 2'b01, 32'hF0F0_1234, 5'd4);
        b_req = 1'b1; b_op = 2'b10; b_data = 32'h8000_00FF; b_amt = 5'd3;
        hs0 = n_hs;
        repeat (7) @(negedge clk);
        @(posedge clk); #1 res_ready = 1'b1;
        begin
            bit got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                got = b_gnt;
            end
            check("bp_b_gnt_after_release", got, 1);
        end
        check("bp_single_handshake", n_hs - hs0, 1);
        @(posedge clk); #1 b_req = 1'b0;
        wait_idle();

        // Contention: both requesting for four grants.
        pulse_reset();
        a_req = 1'b1; a_op = 2'b00; a_data = 32'h0000_0003; a_amt = 5'd2;
        b_req = 1'b1; b_op = 2'b01; b_data = 32'hA000_0000; b_amt = 5'd1;
        for (int i = 0; i < 80 && grants.size() < 4; i++) begin
            @(negedge clk);
            if (a_gnt) grants.push_back(1'b0);
            if (b_gnt) grants.push_back(1'b1);
        end
        @(posedge clk); #1 a_req = 1'b0; b_req = 1'b0;
`ifdef SHIFT_RR_EN
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        check("contention_grant_count", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check($sformatf("contention_grant%0d", i), grants[i], exp_seq[i]);
        wait_idle();

        // Reset while in EXEC: the operation is abandoned.
        hs0 = n_hs;
        issue(1'b0, 2'b00, 32'h0000_FFFF, 5'd4);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_res_valid", res_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_res_data", res_data, 0);
        repeat (4) @(negedge clk);
        check("midrst_no_handshake", n_hs - hs0, 0);

        // Withdrawn A request while busy.
        agnt0 = n_agnt;
        res_ready = 1'b0;
        issue(1'b1, 2'b11, 32'h0F00_0000, 5'd4);
        a_req = 1'b1; a_op = 2'b01; a_data = 32'h1111_1111; a_amt = 5'd1;
        @(posedge clk); #1 a_req = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 res_ready = 1'b1;
        wait_idle();
        repeat (3) @(negedge clk);
        check("withdrawn_no_a_gnt", n_agnt - agnt0, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            a_req     = ($urandom_range(0, 2) == 0);
            b_req     = ($urandom_range(0, 2) == 0);
            a_op      = 2'($urandom_range(0, 3));
            b_op      = 2'($urandom_range(0, 3));
            a_data    = $urandom;
            b_data    = $urandom;
            a_amt     = 5'($urandom_range(0, 31));
            b_amt     = 5'($urandom_range(0, 31));
            res_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        a_req = 1'b0; b_req = 1'b0; res_ready = 1'b1;
        wait_idle();
        check("final_scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shift_unit_arbiter.md
Name: shift_unit_arbiter

Overview:
- Shares one 32-bit shift datapath between two requesters, A (integer ALU path) and B (load/store alignment path). Supported shifts are logical left, logical right, arithmetic right and rotate left.
- Arbitrates between A and B, latches the winner's operands, performs the shift, and holds a registered result until the consumer accepts it.
- Sits between the decode/issue logic and the writeback mux. Only one operation is in flight at a time.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- NUM_WIDTH, 5, shift-amount width. Must equal log2(DATA_WIDTH).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- a_req  input  1  requester A wants a shift. Held with operands until a_gnt.
- a_op  input  2  A's operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- a_data  input  DATA_WIDTH  A's operand.
- a_amt  input  NUM_WIDTH  A's shift amount.
- a_gnt  output  1  one-cycle pulse: A's operands were latched this cycle.
- b_req, b_op, b_data, b_amt, b_gnt: same as the A ports, for requester B.
- res_valid  output  1  result available.
- res_data  output  DATA_WIDTH  shift result.
- res_id  output  1  source of the result: 0 = A, 1 = B.
- res_ready  input  1  consumer accepts the result when res_valid and res_ready are both high.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low at a clock edge):
  - FSM returns to IDLE.
  - a_gnt, b_gnt, res_valid, busy, res_id all 0; res_data = 0.
  - Internal operand, op and amount registers cleared.
  - Priority pointer set to A.
  - Reset mid-operation abandons the in-flight operation; no result is produced.
- FSM states:
  - IDLE:
    - No request: stay in IDLE.
    - Any request: pick the winner (see arbitration rules).
    - Latch the winner's op, data, amt and id.
    - Pulse the winner's gnt for one cycle (registered, asserted in the cycle after the state is entered is NOT allowed; gnt is combinational from the IDLE state and the request, valid in the same cycle the operands are latched).
    - Go to EXEC.
  - EXEC:
    - Compute the shift from the latched operands.
    - Register the result into res_data; set res_valid and res_id.
    - Go to RESP.
  - RESP:
    - Hold res_valid, res_data and res_id stable.
    - When res_ready is 1: clear res_valid and go to IDLE.
    - Otherwise stay in RESP.
    - res_data keeps its last value after it is consumed.
- Latency and throughput:
  - Request sampled at edge t (grant issued); res_valid high from edge t+2.
  - With res_ready tied high, each operation takes 3 cycles.
  - No new grant is issued while busy.
- Arbitration:
  - Without SHIFT_RR_EN: fixed priority, A beats B.
  - When both request in the same cycle, only one gnt fires. The loser keeps req high and is served in the next IDLE.
- Shift arithmetic (result width DATA_WIDTH; amount taken modulo DATA_WIDTH because it is NUM_WIDTH bits):
  - SLL: zero fill.
  - SRL: zero fill.
  - SRA: fill with the sign bit data[DATA_WIDTH-1].
  - ROL: bits shifted out at the MSB re-enter at the LSB.
  - amt = 0: result equals data for all ops.
- Requester rules:
  - A requester may drop req before its gnt; no operation is then issued for it.
  - Operands are sampled only in the gnt cycle.
  - A requester may raise req again in the cycle after its gnt; it is considered at the next IDLE.

Optional Feature:
- Macro: SHIFT_RR_EN.
- Defined: round-robin arbitration.
  - A one-bit pointer names the preferred requester.
  - On each grant, the pointer moves to the non-granted requester.
  - With both requesting continuously, grants alternate A, B, A, B...
  - A lone requester is always granted, whatever the pointer says.
- Undefined: fixed A-over-B priority; no pointer register exists.

Test Plan:
- Reset, then A only: a_req=1, a_op=00, a_data=0x0000_00F1, a_amt=4, res_ready=1.
  - a_gnt pulses at edge t.
  - res_valid=1 at edge t+2 with res_data=0x0000_0F10, res_id=0.
  - busy=0 again at t+3.
- Op coverage on B, amt=8 for all:
  - SRL of 0x8000_0000 -> 0x0080_0000.
  - SRA of 0x8000_0000 -> 0xFF80_0000.
  - ROL of 0x1234_5678 -> 0x3456_7812.
  - SLL with amt=0 -> operand unchanged.
- Backpressure: res_ready=0 for 5 cycles after res_valid.
  - res_valid, res_data and res_id stay stable.
  - b_req held high gets no grant.
  - Raising res_ready gives exactly one handshake, then b_gnt in the following IDLE.
- Contention: a_req and b_req both high for 4 operations, res_ready=1.
  - Without SHIFT_RR_EN: grants A, A, A, A.
  - With SHIFT_RR_EN: grants A, B, A, B.
- Reset mid-operation: assert rst_n=0 during EXEC.
  - Next cycle: res_valid=0, busy=0, res_data=0.
  - No result handshake occurs for the abandoned operation.
- Withdrawn request: a_req pulses for one cycle while busy, then drops before IDLE.
  - No a_gnt.
  - No extra res_valid.
